// File: rtl/dmem_banked_if.sv
// Request/response bus for dmem_banked, plus the operation encodings it shares with the core.
// The master modport is the requester (memory stage); the slave modport is the RAM.
package dmem_banked_pkg;
    typedef enum logic {
        MEM_LOAD  = 1'b0,
        MEM_STORE = 1'b1
    } mem_op_e;

    typedef enum logic [1:0] {
        RAM_MASK_B = 2'd0,
        RAM_MASK_H = 2'd1,
        RAM_MASK_W = 2'd2
    } ram_mask_e;
endpackage

interface dmem_banked_if;
    import dmem_banked_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    mem_op_e     mem_op;
    ram_mask_e   ram_mask;
    logic        load_signed;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req_valid, addr, wdata, mem_op, ram_mask, load_signed,
        input  req_ready, rsp_valid, rdata, err
    );

    modport slave (
        input  req_valid, addr, wdata, mem_op, ram_mask, load_signed,
        output req_ready, rsp_valid, rdata, err
    );
endinterface

// File: rtl/dmem_banked.sv
// Four byte-lane data RAM with registered response, lane write enables and sign-extended loads.
// Define DMEM_MISALIGN_SPLIT_EN to split word-crossing accesses into two beats; else they fault.
module dmem_banked
    import dmem_banked_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 16384,
    parameter string       INIT_FILE   = ""
) (
    input logic          clk,
    input logic          rst_n,
    dmem_banked_if.slave bus
);
    localparam int unsigned Words = DEPTH_BYTES / 4;
    localparam int unsigned Aw    = $clog2(Words);

    logic [1:0]    off;
    logic [Aw-1:0] idx;
    logic [3:0]    size_m;
    logic [7:0]    lanes8;
    logic [63:0]   wdbl;
    logic [31:0]   wrot;
    logic          is_store, misal, accept, beat2;

    logic [Aw-1:0] bank_addr;
    logic [3:0]    bank_we;
    logic [31:0]   bank_wdata, bank_rdata, lanes;
    logic [1:0]    res_off;
    logic [3:0]    res_size;
    logic          res_signed;

    logic [31:0] rdata_q, rdata_d;
    logic        rsp_valid_q, rsp_valid_d, err_q, err_d;

`ifdef DMEM_MISALIGN_SPLIT_EN
    typedef enum logic {StIdle, StBeat2} state_e;
    state_e        state_q, state_d;
    logic [Aw-1:0] nxt_q, nxt_d;
    logic [31:0]   hold_q, hold_d, wrot_q, wrot_d;
    logic [3:0]    hi_q, hi_d, size_q, size_d;
    logic [1:0]    off_q, off_d;
    logic          signed_q, signed_d, store_q, store_d;
    assign beat2 = (state_q == StBeat2);
`else
    assign beat2 = 1'b0;
`endif

    // Byte k of the access lives in lane (off+k)%4; upper nibble of lanes8 spills into next word.
    always_comb begin
        off = bus.addr[1:0];
        idx = bus.addr[Aw+1:2];
        case (bus.ram_mask)
            RAM_MASK_B: size_m = 4'b0001;
            RAM_MASK_H: size_m = 4'b0011;
            default:    size_m = 4'b1111;
        endcase
        lanes8   = {4'b0000, size_m} << off;
        wdbl     = {bus.wdata, bus.wdata} << {off, 3'b000};
        wrot     = wdbl[63:32];
        is_store = (bus.mem_op == MEM_STORE);
        misal    = ((size_m == 4'b0011) && off[0]) || ((size_m == 4'b1111) && (off != 2'd0));
    end

    assign bus.req_ready = rst_n && !beat2;
    assign accept        = bus.req_valid && bus.req_ready;

    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [7:0] mem_q [Words];
        always_ff @(posedge clk) begin
            if (bank_we[b]) mem_q[bank_addr] <= bank_wdata[8*b +: 8];
        end
        assign bank_rdata[8*b +: 8] = mem_q[bank_addr];
    end

    function automatic logic [31:0] load_result(logic [31:0] lw, logic [1:0] o, logic [3:0] sz,
                                                logic sgn);
        logic [63:0] dbl;
        logic [31:0] a;
        dbl = {lw, lw} >> {o, 3'b000};
        a   = dbl[31:0];
        case (sz)
            4'b0001: return {{24{sgn & a[7]}}, a[7:0]};
            4'b0011: return {{16{sgn & a[15]}}, a[15:0]};
            default: return a;
        endcase
    endfunction

    always_comb begin
        bank_addr   = idx;
        bank_we     = 4'b0000;
        bank_wdata  = wrot;
        lanes       = bank_rdata;
        res_off     = off;
        res_size    = size_m;
        res_signed  = bus.load_signed;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        err_d       = 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
        state_d  = state_q;
        nxt_d    = nxt_q;
        hold_d   = hold_q;
        wrot_d   = wrot_q;
        hi_d     = hi_q;
        size_d   = size_q;
        off_d    = off_q;
        signed_d = signed_q;
        store_d  = store_q;
        if (beat2) begin
            bank_addr  = nxt_q;
            bank_wdata = wrot_q;
            bank_we    = (store_q && rst_n) ? hi_q : 4'b0000;
            for (int b = 0; b < 4; b++) begin
                lanes[8*b +: 8] = hi_q[b] ? bank_rdata[8*b +: 8] : hold_q[8*b +: 8];
            end
            res_off     = off_q;
            res_size    = size_q;
            res_signed  = signed_q;
            rsp_valid_d = 1'b1;
            rdata_d     = store_q ? 32'h0 : load_result(lanes, res_off, res_size, res_signed);
            state_d     = StIdle;
        end else if (accept) begin
            bank_we = is_store ? lanes8[3:0] : 4'b0000;
            if (|lanes8[7:4]) begin
                state_d  = StBeat2;
                nxt_d    = idx + 1'b1;
                hold_d   = bank_rdata;
                wrot_d   = wrot;
                hi_d     = lanes8[7:4];
                size_d   = size_m;
                off_d    = off;
                signed_d = bus.load_signed;
                store_d  = is_store;
            end else begin
                rsp_valid_d = 1'b1;
                rdata_d     = is_store ? 32'h0 : load_result(lanes, res_off, res_size, res_signed);
            end
        end
`else
        if (accept) begin
            rsp_valid_d = 1'b1;
            err_d       = misal;
            bank_we     = (is_store && !misal) ? lanes8[3:0] : 4'b0000;
            rdata_d     = (is_store || misal) ? 32'h0 :
                          load_result(lanes, res_off, res_size, res_signed);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
            state_q  <= StIdle;
            nxt_q    <= '0;
            hold_q   <= '0;
            wrot_q   <= '0;
            hi_q     <= '0;
            size_q   <= '0;
            off_q    <= '0;
            signed_q <= 1'b0;
            store_q  <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
`ifdef DMEM_MISALIGN_SPLIT_EN
            state_q  <= state_d;
            nxt_q    <= nxt_d;
            hold_q   <= hold_d;
            wrot_q   <= wrot_d;
            hi_q     <= hi_d;
            size_q   <= size_d;
            off_q    <= off_d;
            signed_q <= signed_d;
            store_q  <= store_d;
`endif
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;

    logic unused_bits;
`ifdef DMEM_MISALIGN_SPLIT_EN
    assign unused_bits = ^{bus.addr[31:Aw+2], misal};
`else
    assign unused_bits = ^{bus.addr[31:Aw+2], lanes8[7:4]};
`endif
endmodule

// File: tb/tb_dmem_banked.sv
// Directed bench for dmem_banked: vector table for single accesses plus hand sequences for
// reset, back-to-back and two-beat (or faulting) word-crossing accesses.
module tb_dmem_banked;
    import dmem_banked_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_banked_if bus();

    dmem_banked #(
        .DEPTH_BYTES(16384),
        .INIT_FILE  ("")
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        mem_op_e     op;
        ram_mask_e   mask;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input mem_op_e op, input ram_mask_e mask,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        vec_t v;
        v.name = name; v.op = op; v.mask = mask; v.sgn = sgn; v.addr = addr;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        vecs.push_back(v);
    endtask

    task automatic drive(input mem_op_e op, input ram_mask_e mask, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid   = 1'b1;
        bus.mem_op      = op;
        bus.ram_mask    = mask;
        bus.load_signed = sgn;
        bus.addr        = addr;
        bus.wdata       = wdata;
    endtask

    // One request; lat counts cycles from accept edge to the cycle rsp_valid is seen (-1 = none).
    task automatic txn(input mem_op_e op, input ram_mask_e mask, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic er, output int lat);
        int waited;
        @(negedge clk);
        drive(op, mask, sgn, addr, wdata);
        #1;
        waited = 0;
        while (!bus.req_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: req_ready=0 after %0d cycles, required 1", waited);
            bus.req_valid = 1'b0;
            rd = 32'h0; er = 1'b0; lat = -1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 4) begin
            @(negedge clk);
            lat++;
        end
        rd = bus.rdata;
        er = bus.err;
        if (!bus.rsp_valid) lat = -1;
    endtask

    task automatic txn_chk(input string name, input mem_op_e op, input ram_mask_e mask,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        txn(op, mask, sgn, addr, wdata, rd, er, lat);
        check({name, "/rdata"}, rd, exp_rdata);
        check({name, "/err"}, 32'(er), 32'(exp_err));
        check({name, "/lat"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid   = 1'b0;
        bus.mem_op      = MEM_LOAD;
        bus.ram_mask    = RAM_MASK_W;
        bus.load_signed = 1'b0;
        bus.addr        = 32'h0;
        bus.wdata       = 32'h0;

        // Reset held with a store pending: never ready, never responds.
        rst_n = 1'b0;
        drive(MEM_STORE, RAM_MASK_W, 1'b0, 32'h0, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_req_ready", 32'(bus.req_ready), 32'h0);
            check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        end
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("post_rst_req_ready", 32'(bus.req_ready), 32'h1);
        check("post_rst_rdata", bus.rdata, 32'h0);
        check("post_rst_err", 32'(bus.err), 32'h0);

        add("sw_base",   MEM_STORE, RAM_MASK_W, 0, 32'h100, 32'h11223344, 32'h0, 0, 1);
        add("sb_lane2",  MEM_STORE, RAM_MASK_B, 0, 32'h102, 32'h000000AA, 32'h0, 0, 1);
        add("lw_merged", MEM_LOAD,  RAM_MASK_W, 0, 32'h100, 32'h0, 32'h11AA3344, 0, 1);
        add("lb_signed", MEM_LOAD,  RAM_MASK_B, 1, 32'h102, 32'h0, 32'hFFFFFFAA, 0, 1);
        add("lb_zero",   MEM_LOAD,  RAM_MASK_B, 0, 32'h102, 32'h0, 32'h000000AA, 0, 1);
        add("sh_8001",   MEM_STORE, RAM_MASK_H, 0, 32'h20A, 32'h00008001, 32'h0, 0, 1);
        add("lh_signed", MEM_LOAD,  RAM_MASK_H, 1, 32'h20A, 32'h0, 32'hFFFF8001, 0, 1);
        add("lh_zero",   MEM_LOAD,  RAM_MASK_H, 0, 32'h20A, 32'h0, 32'h00008001, 0, 1);
        add("lb_hi_s",   MEM_LOAD,  RAM_MASK_B, 1, 32'h20B, 32'h0, 32'hFFFFFF80, 0, 1);
        add("lb_lo_u",   MEM_LOAD,  RAM_MASK_B, 0, 32'h20A, 32'h0, 32'h00000001, 0, 1);
        add("lw_mask3",  MEM_LOAD,  ram_mask_e'(2'd3), 0, 32'h100, 32'h0, 32'h11AA3344, 0, 1);
        add("lw_sgn_ig", MEM_LOAD,  RAM_MASK_W, 1, 32'h100, 32'h0, 32'h11AA3344, 0, 1);
        add("sb_upper",  MEM_STORE, RAM_MASK_B, 0, 32'h103, 32'h12345677, 32'h0, 0, 1);
        add("lw_wrap1",  MEM_LOAD,  RAM_MASK_W, 0, 32'h4100, 32'h0, 32'h77AA3344, 0, 1);
        add("lw_wrap2",  MEM_LOAD,  RAM_MASK_W, 0, 32'hFFFF0100, 32'h0, 32'h77AA3344, 0, 1);
        add("sh_upper",  MEM_STORE, RAM_MASK_H, 0, 32'h20A, 32'hABCD5A5A, 32'h0, 0, 1);
        add("lh_5a5a",   MEM_LOAD,  RAM_MASK_H, 0, 32'h20A, 32'h0, 32'h00005A5A, 0, 1);
        add("lb_odd",    MEM_LOAD,  RAM_MASK_B, 0, 32'h101, 32'h0, 32'h00000033, 0, 1);
`ifdef DMEM_MISALIGN_SPLIT_EN
        add("sh_off1",   MEM_STORE, RAM_MASK_H, 0, 32'h101, 32'h00005555, 32'h0, 0, 1);
        add("lw_off1",   MEM_LOAD,  RAM_MASK_W, 0, 32'h100, 32'h0, 32'h77555544, 0, 1);
        add("lh_off1",   MEM_LOAD,  RAM_MASK_H, 0, 32'h101, 32'h0, 32'h00005555, 0, 1);
`else
        add("sh_mis",    MEM_STORE, RAM_MASK_H, 0, 32'h101, 32'h00005555, 32'h0, 1, 1);
        add("lw_nowr",   MEM_LOAD,  RAM_MASK_W, 0, 32'h100, 32'h0, 32'h77AA3344, 0, 1);
        add("lh_mis",    MEM_LOAD,  RAM_MASK_H, 1, 32'h101, 32'h0, 32'h0, 1, 1);
        add("lw_mis",    MEM_LOAD,  RAM_MASK_W, 0, 32'h102, 32'h0, 32'h0, 1, 1);
`endif

        foreach (vecs[i]) begin
            txn_chk(vecs[i].name, vecs[i].op, vecs[i].mask, vecs[i].sgn, vecs[i].addr,
                    vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat);
        end

        // Back-to-back store then load of the same word.
        @(negedge clk);
        drive(MEM_STORE, RAM_MASK_W, 1'b0, 32'h40, 32'hDEADBEEF);
        @(posedge clk);
        @(negedge clk);
        check("b2b_st_rsp", 32'(bus.rsp_valid), 32'h1);
        check("b2b_st_rdata", bus.rdata, 32'h0);
        check("b2b_ready", 32'(bus.req_ready), 32'h1);
        drive(MEM_LOAD, RAM_MASK_W, 1'b0, 32'h40, 32'h0);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("b2b_ld_rsp", 32'(bus.rsp_valid), 32'h1);
        check("b2b_ld_rdata", bus.rdata, 32'hDEADBEEF);
        @(negedge clk);
        check("b2b_rsp_pulse", 32'(bus.rsp_valid), 32'h0);
        check("b2b_rdata_hold", bus.rdata, 32'hDEADBEEF);

        // Reset blocks a store held on the bus.
        txn_chk("sw_zero", MEM_STORE, RAM_MASK_W, 0, 32'h0, 32'h13579BDF, 32'h0, 0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        drive(MEM_STORE, RAM_MASK_W, 1'b0, 32'h0, 32'hFFFFFFFF);
        repeat (3) @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        txn_chk("rst_nowrite", MEM_LOAD, RAM_MASK_W, 0, 32'h0, 32'h0, 32'h13579BDF, 0, 1);

        txn_chk("sw_0000", MEM_STORE, RAM_MASK_W, 0, 32'h0, 32'h01020304, 32'h0, 0, 1);
        txn_chk("sw_3ffc", MEM_STORE, RAM_MASK_W, 0, 32'h3FFC, 32'h99887766, 32'h0, 0, 1);
`ifdef DMEM_MISALIGN_SPLIT_EN
        // Split store across the top of memory, with a load held during the second beat.
        @(negedge clk);
        drive(MEM_STORE, RAM_MASK_W, 1'b0, 32'h3FFE, 32'hA1B2C3D4);
        @(posedge clk);
        @(negedge clk);
        check("split_ready_low", 32'(bus.req_ready), 32'h0);
        check("split_no_rsp1", 32'(bus.rsp_valid), 32'h0);
        drive(MEM_LOAD, RAM_MASK_W, 1'b0, 32'h3FFC, 32'h0);
        @(negedge clk);
        check("split_rsp2", 32'(bus.rsp_valid), 32'h1);
        check("split_err", 32'(bus.err), 32'h0);
        check("split_ready_back", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("held_ld_rsp", 32'(bus.rsp_valid), 32'h1);
        check("held_ld_rdata", bus.rdata, 32'hC3D47766);
        txn_chk("lw_split",  MEM_LOAD, RAM_MASK_W, 0, 32'h3FFE, 32'h0, 32'hA1B2C3D4, 0, 2);
        txn_chk("lw_wrapped", MEM_LOAD, RAM_MASK_W, 0, 32'h0, 32'h0, 32'h0102A1B2, 0, 1);
        txn_chk("lh_split_u", MEM_LOAD, RAM_MASK_H, 0, 32'h3FFF, 32'h0, 32'h0000B2C3, 0, 2);
        txn_chk("lh_split_s", MEM_LOAD, RAM_MASK_H, 1, 32'h3FFF, 32'h0, 32'hFFFFB2C3, 0, 2);

        // Reset during the second beat: beat-1 byte lands, beat-2 bytes and response do not.
        @(negedge clk);
        drive(MEM_STORE, RAM_MASK_W, 1'b0, 32'h3FFF, 32'h55667788);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("beat2_rst_ready", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        check("beat2_rst_norsp", 32'(bus.rsp_valid), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("beat2_rst_norsp2", 32'(bus.rsp_valid), 32'h0);
        txn_chk("beat2_rst_w0", MEM_LOAD, RAM_MASK_W, 0, 32'h0, 32'h0, 32'h0102A1B2, 0, 1);
        txn_chk("beat1_kept", MEM_LOAD, RAM_MASK_B, 0, 32'h3FFF, 32'h0, 32'h00000088, 0, 1);
`else
        txn_chk("sw_cross_err", MEM_STORE, RAM_MASK_W, 0, 32'h3FFE, 32'hA1B2C3D4, 32'h0, 1, 1);
        txn_chk("cross_nowr", MEM_LOAD, RAM_MASK_W, 0, 32'h3FFC, 32'h0, 32'h99887766, 0, 1);
        txn_chk("cross_nowr0", MEM_LOAD, RAM_MASK_W, 0, 32'h0, 32'h0, 32'h01020304, 0, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
